// File: rtl/seg7_reader.sv
// -----------------------------------------------------------------------------
// seg7_reader
//   Watches a captured 7-segment display bus and recovers the hex digit shown.
//   A pattern must be stable for STABLE_CYCLES sampled cycles before it is
//   accepted. Each newly shown digit is offered once on a valid/ready
//   handshake. Patterns that are not legal glyphs are flagged with dig_err.
//   Accepted legal digits are counted.
//
//   Optional build macro: SEG7_ALT_GLYPH_EN
//     When defined, the alternate glyphs 7'h27 (seven with F lit) and 7'h67
//     (nine without D) are also decoded as legal digits.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : synchronous, active-high reset
//   seg_in     : segment lines {G,F,E,D,C,B,A}, bit0 = A, 1 = lit
//   dig_ready  : downstream accepts dig_out this cycle
//   dig_out    : decoded hex value (0 when dig_err is set)
//   dig_valid  : dig_out/dig_err valid
//   dig_err    : presented pattern is not a legal glyph
//   err_sticky : set by any handshake with dig_err = 1, cleared only by reset
//   dig_count  : number of legal digits accepted (wraps)
// -----------------------------------------------------------------------------
module seg7_reader #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       seg_in,
    input  logic             dig_ready,
    output logic [3:0]       dig_out,
    output logic             dig_valid,
    output logic             dig_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] dig_count
);

    localparam logic [3:0] STABLE_LIM = 4'(STABLE_CYCLES);

    typedef enum logic [0:0] {
        ST_SETTLE  = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    // Returns {illegal, value}; illegal patterns decode to value 0.
    function automatic logic [4:0] glyph_decode(input logic [6:0] pat);
        logic [4:0] res;
        case (pat)
            7'h3F:   res = {1'b0, 4'h0};
            7'h06:   res = {1'b0, 4'h1};
            7'h5B:   res = {1'b0, 4'h2};
            7'h4F:   res = {1'b0, 4'h3};
            7'h66:   res = {1'b0, 4'h4};
            7'h6D:   res = {1'b0, 4'h5};
            7'h7D:   res = {1'b0, 4'h6};
            7'h07:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h6F:   res = {1'b0, 4'h9};
            7'h77:   res = {1'b0, 4'hA};
            7'h7C:   res = {1'b0, 4'hB};
            7'h39:   res = {1'b0, 4'hC};
            7'h5E:   res = {1'b0, 4'hD};
            7'h79:   res = {1'b0, 4'hE};
            7'h71:   res = {1'b0, 4'hF};
`ifdef SEG7_ALT_GLYPH_EN
            7'h27:   res = {1'b0, 4'h7};
            7'h67:   res = {1'b0, 4'h9};
`endif
            default: res = {1'b1, 4'h0};
        endcase
        return res;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [6:0]       seg_q_r;
    logic [6:0]       cand_r;
    logic [6:0]       cand_nxt_s;
    logic [3:0]       stab_cnt_r;
    logic [3:0]       stab_nxt_s;
    logic [6:0]       last_r;
    logic [6:0]       last_nxt_s;
    logic [3:0]       dig_out_nxt_s;
    logic             dig_err_nxt_s;
    logic             dig_valid_nxt_s;
    logic             sticky_nxt_s;
    logic [CNT_W-1:0] count_nxt_s;
    logic [4:0]       decode_s;

    // Next-state and next-output logic for the settle/present handshake FSM.
    always_comb begin
        state_nxt_s     = state_r;
        cand_nxt_s      = cand_r;
        stab_nxt_s      = stab_cnt_r;
        last_nxt_s      = last_r;
        dig_out_nxt_s   = dig_out;
        dig_err_nxt_s   = dig_err;
        dig_valid_nxt_s = dig_valid;
        sticky_nxt_s    = err_sticky;
        count_nxt_s     = dig_count;
        decode_s        = glyph_decode(seg_q_r);

        case (state_r)
            ST_SETTLE: begin
                if (seg_q_r != cand_r) begin
                    cand_nxt_s = seg_q_r;
                    stab_nxt_s = 4'd1;
                end else if (stab_cnt_r < STABLE_LIM) begin
                    stab_nxt_s = stab_cnt_r + 4'd1;
                end else begin
                    stab_nxt_s = STABLE_LIM;
                end

                // Decide on the edge where the count reaches the threshold so
                // the digit appears STABLE_CYCLES edges after its capture.
                // At that point the candidate always equals seg_q_r.
                if (stab_nxt_s == STABLE_LIM) begin
                    if (seg_q_r == 7'h00) begin
                        last_nxt_s = 7'h00;
                    end else if (seg_q_r == last_r) begin
                        state_nxt_s = ST_SETTLE;
                    end else begin
                        dig_out_nxt_s   = decode_s[3:0];
                        dig_err_nxt_s   = decode_s[4];
                        dig_valid_nxt_s = 1'b1;
                        state_nxt_s     = ST_PRESENT;
                    end
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end

            ST_PRESENT: begin
                // dig_valid is always high here, so ready alone completes it.
                if (dig_ready) begin
                    dig_valid_nxt_s = 1'b0;
                    last_nxt_s      = cand_r;
                    stab_nxt_s      = 4'd0;
                    state_nxt_s     = ST_SETTLE;
                    if (dig_err) begin
                        sticky_nxt_s = 1'b1;
                    end else begin
                        count_nxt_s = dig_count + CNT_W'(1);
                    end
                end else begin
                    state_nxt_s = ST_PRESENT;
                end
            end

            default: begin
                state_nxt_s = ST_SETTLE;
            end
        endcase
    end

    // State, input capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= ST_SETTLE;
            seg_q_r    <= 7'h00;
            cand_r     <= 7'h00;
            stab_cnt_r <= 4'd0;
            last_r     <= 7'h00;
            dig_out    <= 4'h0;
            dig_valid  <= 1'b0;
            dig_err    <= 1'b0;
            err_sticky <= 1'b0;
            dig_count  <= '0;
        end else begin
            state_r    <= state_nxt_s;
            seg_q_r    <= seg_in;
            cand_r     <= cand_nxt_s;
            stab_cnt_r <= stab_nxt_s;
            last_r     <= last_nxt_s;
            dig_out    <= dig_out_nxt_s;
            dig_valid  <= dig_valid_nxt_s;
            dig_err    <= dig_err_nxt_s;
            err_sticky <= sticky_nxt_s;
            dig_count  <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_seg7_reader.sv
module tb_seg7_reader;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [6:0] seg_in;
    logic       dig_ready;
    logic [3:0] dig_out;
    logic       dig_valid;
    logic       dig_err;
    logic       err_sticky;
    logic [7:0] dig_count;

    int vectors     = 0;
    int miscompares = 0;

    seg7_reader #(.STABLE_CYCLES(STABLE), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .dig_ready  (dig_ready),
        .dig_out    (dig_out),
        .dig_valid  (dig_valid),
        .dig_err    (dig_err),
        .err_sticky (err_sticky),
        .dig_count  (dig_count)
    );

    always #5 clk = ~clk;

    // Reference model: the glyph for value v is glyphs[v].
    logic [6:0] glyphs [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    logic [6:0] m_seg_q, m_last, m_pat;
    logic       m_present, m_valid, m_err, m_sticky;
    logic [3:0] m_out;
    logic [7:0] m_count;
    logic [6:0] hist [$];

    // Handshake log: values seen on cycles where the bench drives ready with valid up.
    logic [3:0] hs_out [$];
    logic       hs_err [$];

    function automatic logic [4:0] model_decode(input logic [6:0] p);
        for (int v = 0; v < 16; v++) begin
            if (glyphs[v] == p) return {1'b0, 4'(v)};
        end
`ifdef SEG7_ALT_GLYPH_EN
        if (p == 7'h27) return {1'b0, 4'h7};
        if (p == 7'h67) return {1'b0, 4'h9};
`endif
        return {1'b1, 4'h0};
    endfunction

    // One clock edge of the reference: run-length of identical samples since
    // the last return to settling decides acceptance.
    task automatic model_step(input logic [6:0] s, input logic r, input logic rst);
        logic       all_eq;
        logic [6:0] p;
        logic [4:0] d;
        if (rst) begin
            m_seg_q = 7'h00; m_last = 7'h00; m_pat = 7'h00;
            m_present = 1'b0; m_valid = 1'b0; m_err = 1'b0; m_sticky = 1'b0;
            m_out = 4'h0; m_count = 8'd0;
            hist.delete();
        end else begin
            if (m_present) begin
                if (r) begin
                    m_present = 1'b0;
                    m_valid   = 1'b0;
                    m_last    = m_pat;
                    if (m_err) m_sticky = 1'b1;
                    else       m_count  = m_count + 8'd1;
                    hist.delete();
                end
            end else begin
                hist.push_back(m_seg_q);
                if (hist.size() > STABLE) void'(hist.pop_front());
                if (hist.size() == STABLE) begin
                    all_eq = 1'b1;
                    foreach (hist[i]) if (hist[i] != hist[0]) all_eq = 1'b0;
                    p = hist[0];
                    if (all_eq) begin
                        if (p == 7'h00) begin
                            m_last = 7'h00;
                        end else if (p != m_last) begin
                            d = model_decode(p);
                            m_out = d[3:0]; m_err = d[4];
                            m_valid = 1'b1; m_present = 1'b1; m_pat = p;
                        end
                    end
                end
            end
            m_seg_q = s;
        end
    endtask

    task automatic tick(input logic [6:0] s, input logic r, input logic rst);
        if (dig_valid && r && !rst) begin
            hs_out.push_back(dig_out);
            hs_err.push_back(dig_err);
        end
        seg_in = s; dig_ready = r; reset = rst;
        @(posedge clk);
        model_step(s, r, rst);
        #1;
    endtask

    task automatic clear_log();
        hs_out.delete();
        hs_err.delete();
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick(7'($urandom), 1'($urandom), 1'b1);
            vectors++;
            if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== 15'd0) begin
                miscompares++;
                $display("FAIL reset_state: got %h want 0000", {dig_valid, dig_out, dig_err, err_sticky, dig_count});
            end
        end
    endtask

    task automatic test_single();
        int first_idx = -1;
        tick(7'h00, 1'b1, 1'b1);
        clear_log();
        for (int i = 0; i < 14; i++) begin
            tick(7'h06, 1'b1, 1'b0);
            if (dig_valid && first_idx < 0) first_idx = i;
            vectors++;
            if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                miscompares++;
                $display("FAIL single cyc%0d: got %h want %h", i, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
            end
        end
        vectors++;
        if (first_idx != STABLE) begin
            miscompares++;
            $display("FAIL single_latency: got %0d want %0d", first_idx, STABLE);
        end
        vectors++;
        if (hs_out.size() != 1 || hs_out[0] !== 4'h1 || hs_err[0] !== 1'b0 || dig_count !== 8'd1) begin
            miscompares++;
            $display("FAIL single_once: got %0d handshakes count %0d want 1 handshake of 1, count 1", hs_out.size(), dig_count);
        end
    endtask

    task automatic test_toggle();
        int early = 0;
        tick(7'h00, 1'b1, 1'b1);
        clear_log();
        for (int i = 0; i < 20; i++) begin
            tick(((i / 2) % 2 == 0) ? 7'h5B : 7'h4F, 1'b1, 1'b0);
            if (dig_valid) early++;
            vectors++;
            if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                miscompares++;
                $display("FAIL toggle cyc%0d: got %h want %h", i, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
            end
        end
        for (int i = 0; i < 10; i++) tick(7'h4F, 1'b1, 1'b0);
        vectors++;
        if (early != 0 || hs_out.size() != 1 || hs_out[0] !== 4'h3) begin
            miscompares++;
            $display("FAIL toggle_filter: got %0d early valids, %0d handshakes want 0 early, 1 handshake of 3", early, hs_out.size());
        end
    endtask

    task automatic test_backpressure();
        tick(7'h00, 1'b1, 1'b1);
        clear_log();
        for (int i = 0; i < 12; i++) begin
            tick((i < 5) ? 7'h7F : 7'h3F, 1'b0, 1'b0);
            vectors++;
            if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                miscompares++;
                $display("FAIL backpressure cyc%0d: got %h want %h", i, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
            end
        end
        vectors++;
        if (dig_valid !== 1'b1 || dig_out !== 4'h8) begin
            miscompares++;
            $display("FAIL backpressure_hold: got valid %b out %h want valid 1 out 8", dig_valid, dig_out);
        end
        for (int i = 0; i < 10; i++) tick(7'h3F, 1'b1, 1'b0);
        vectors++;
        if (hs_out.size() != 2 || hs_out[0] !== 4'h8 || hs_out[1] !== 4'h0 || dig_count !== 8'd2) begin
            miscompares++;
            $display("FAIL backpressure_seq: got %0d handshakes count %0d want 8 then 0, count 2", hs_out.size(), dig_count);
        end
    endtask

    task automatic test_blank_repeat();
        tick(7'h00, 1'b1, 1'b1);
        clear_log();
        for (int i = 0; i < 30; i++) begin
            tick((i >= 8 && i < 14) ? 7'h00 : 7'h6D, 1'b1, 1'b0);
            vectors++;
            if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                miscompares++;
                $display("FAIL blank cyc%0d: got %h want %h", i, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
            end
        end
        vectors++;
        if (hs_out.size() != 2 || hs_out[0] !== 4'h5 || hs_out[1] !== 4'h5 || dig_count !== 8'd2) begin
            miscompares++;
            $display("FAIL blank_rearm: got %0d handshakes count %0d want 2 of 5, count 2", hs_out.size(), dig_count);
        end
    endtask

    task automatic test_illegal();
        logic [4:0] exp_alt;
`ifdef SEG7_ALT_GLYPH_EN
        exp_alt = {1'b0, 4'h7};
`else
        exp_alt = {1'b1, 4'h0};
`endif
        tick(7'h00, 1'b1, 1'b1);
        clear_log();
        for (int i = 0; i < 20; i++) begin
            tick((i < 10) ? 7'h55 : 7'h27, 1'b1, 1'b0);
            vectors++;
            if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                miscompares++;
                $display("FAIL illegal cyc%0d: got %h want %h", i, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
            end
            if (i == 9) begin
                vectors++;
                if (hs_out.size() != 1 || hs_err[0] !== 1'b1 || hs_out[0] !== 4'h0 || err_sticky !== 1'b1 || dig_count !== 8'd0) begin
                    miscompares++;
                    $display("FAIL illegal_flag: got %0d handshakes sticky %b count %0d want 1 err handshake, sticky 1, count 0", hs_out.size(), err_sticky, dig_count);
                end
            end
        end
        vectors++;
        if (hs_out.size() != 2) begin
            miscompares++;
            $display("FAIL alt_glyph_seen: got %0d handshakes want 2", hs_out.size());
        end else if ({hs_err[1], hs_out[1]} !== exp_alt) begin
            miscompares++;
            $display("FAIL alt_glyph: got %h want %h", {hs_err[1], hs_out[1]}, exp_alt);
        end
    endtask

    task automatic test_wrap();
        tick(7'h00, 1'b1, 1'b1);
        clear_log();
        for (int n = 0; n < 256; n++) begin
            for (int c = 0; c < 6; c++) begin
                tick((n % 2 == 0) ? 7'h3F : 7'h06, 1'b1, 1'b0);
                vectors++;
                if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                    miscompares++;
                    $display("FAIL wrap n%0d c%0d: got %h want %h", n, c, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
                end
            end
        end
        tick(7'h06, 1'b1, 1'b0);
        vectors++;
        if (hs_out.size() != 256 || dig_count !== 8'd0) begin
            miscompares++;
            $display("FAIL wrap_count: got %0d handshakes count %0d want 256, count 0", hs_out.size(), dig_count);
        end
    endtask

    task automatic test_reset_mid_present();
        tick(7'h00, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) tick(7'h77, 1'b0, 1'b0);
        vectors++;
        if (dig_valid !== 1'b1 || dig_out !== 4'hA) begin
            miscompares++;
            $display("FAIL midreset_pre: got valid %b out %h want valid 1 out a", dig_valid, dig_out);
        end
        tick(7'h77, 1'b1, 1'b1);
        vectors++;
        if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== 15'd0) begin
            miscompares++;
            $display("FAIL midreset: got %h want 0000", {dig_valid, dig_out, dig_err, err_sticky, dig_count});
        end
    endtask

    task automatic test_random();
        logic [6:0] pat;
        int         hold;
        int         cyc = 0;
        tick(7'h00, 1'b1, 1'b1);
        while (cyc < 3000) begin
            case ($urandom_range(0, 5))
                0:       pat = 7'h00;
                1:       pat = 7'h55;
                2:       pat = ($urandom_range(0, 1) == 0) ? 7'h27 : 7'h67;
                3:       pat = 7'($urandom);
                default: pat = glyphs[$urandom_range(0, 15)];
            endcase
            hold = $urandom_range(1, 9);
            for (int h = 0; h < hold; h++) begin
                tick(pat, 1'($urandom_range(0, 1)), ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
                cyc++;
                vectors++;
                if ({dig_valid, dig_out, dig_err, err_sticky, dig_count} !== {m_valid, m_out, m_err, m_sticky, m_count}) begin
                    miscompares++;
                    $display("FAIL random cyc%0d: got %h want %h", cyc, {dig_valid, dig_out, dig_err, err_sticky, dig_count}, {m_valid, m_out, m_err, m_sticky, m_count});
                end
            end
        end
    endtask

    initial begin
        reset = 1'b1; seg_in = 7'h00; dig_ready = 1'b0;
        test_reset();
        test_single();
        test_toggle();
        test_backpressure();
        test_blank_repeat();
        test_illegal();
        test_wrap();
        test_reset_mid_present();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
